core_bus_arbiter: RTL and testbench

Shares one peripheral core's register port between two bus requesters (m0: CPU, m1: DMA).
- Arbitrates between them round-robin.
- Decodes the register address into one-hot write/read strobes toward the core.
- Returns read data or an error with a single-cycle ack.
- Sits between the system bus fabric and the core's register interface (core_io out-side signals).

---
 rtl/core_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter in front of a core register port: IDLE -> ACCESS -> RESP.
// Optional build macro ARB_FIXED_PRIO_EN: m0 always wins simultaneous requests (default: round-robin).
module core_bus_arbiter #(
   parameter int REGS   = 3,
   parameter int ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [31:0]           m0_wdata,
   output logic                  m0_ack,
   output logic                  m0_err,
   output logic [31:0]           m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [31:0]           m1_wdata,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic [31:0]           m1_rdata,
   output logic [31:0]           core_data_in,
   input  logic [32*REGS-1:0]    core_data_out,
   output logic [REGS-1:0]       core_write_en,
   output logic [REGS-1:0]       core_read_en
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_last_grant;
   logic                r_sel;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_err;
   logic [REGS-1:0]     r_write_en;
   logic [REGS-1:0]     r_read_en;
   logic [31:0]         r_data_in;
   logic                r_m0_ack;
   logic                r_m0_err;
   logic [31:0]         r_m0_rdata;
   logic                r_m1_ack;
   logic                r_m1_err;
   logic [31:0]         r_m1_rdata;

   logic                w_any_req;
   logic                w_grant;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [31:0]         w_sel_wdata;
   logic                w_sel_valid;
   logic [REGS-1:0]     w_dec;
   logic [31:0]         w_rd_word;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return ({{(32-ADDR_W){1'b0}}, a} < 32'(REGS));
   endfunction

   // Pick the winner among pending requesters
   always_comb begin
      w_any_req = m0_req | m1_req;
      w_grant   = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      w_grant = m0_req ? 1'b0 : 1'b1;
`else
      if (m0_req && m1_req) begin
         w_grant = ~r_last_grant;
      end else begin
         w_grant = m0_req ? 1'b0 : 1'b1;
      end
`endif
   end

   // Mux the winning requester's command and decode its address
   always_comb begin
      w_sel_we    = w_grant ? m1_we    : m0_we;
      w_sel_addr  = w_grant ? m1_addr  : m0_addr;
      w_sel_wdata = w_grant ? m1_wdata : m0_wdata;
      w_sel_valid = addr_in_range(w_sel_addr);
      w_dec       = '0;
      for (int i = 0; i < REGS; i++) begin
         w_dec[i] = (w_sel_addr == ADDR_W'(i));
      end
   end

   // Select the addressed core register for read capture
   always_comb begin
      w_rd_word = 32'd0;
      for (int i = 0; i < REGS; i++) begin
         w_rd_word = w_rd_word | ({32{r_addr == ADDR_W'(i)}} & core_data_out[i*32 +: 32]);
      end
   end

   // Transaction FSM with all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_sel        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_err        <= 1'b0;
         r_write_en   <= '0;
         r_read_en    <= '0;
         r_data_in    <= 32'd0;
         r_m0_ack     <= 1'b0;
         r_m0_err     <= 1'b0;
         r_m0_rdata   <= 32'd0;
         r_m1_ack     <= 1'b0;
         r_m1_err     <= 1'b0;
         r_m1_rdata   <= 32'd0;
      end else begin
         r_write_en <= '0;
         r_read_en  <= '0;
         r_data_in  <= 32'd0;
         r_m0_ack   <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m0_rdata <= 32'd0;
         r_m1_ack   <= 1'b0;
         r_m1_err   <= 1'b0;
         r_m1_rdata <= 32'd0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_sel        <= w_grant;
                  r_we         <= w_sel_we;
                  r_addr       <= w_sel_addr;
                  r_err        <= ~w_sel_valid;
                  r_last_grant <= w_grant;
                  // Strobes are launched here so they are live for exactly the ACCESS cycle
                  r_write_en   <= (w_sel_we  && w_sel_valid) ? w_dec : '0;
                  r_read_en    <= (!w_sel_we && w_sel_valid) ? w_dec : '0;
                  r_data_in    <= (w_sel_we  && w_sel_valid) ? w_sel_wdata : 32'd0;
                  r_state      <= ST_ACCESS;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (r_sel == 1'b0) begin
                  r_m0_ack   <= 1'b1;
                  r_m0_err   <= r_err;
                  r_m0_rdata <= (!r_we && !r_err) ? w_rd_word : 32'd0;
               end else begin
                  r_m1_ack   <= 1'b1;
                  r_m1_err   <= r_err;
                  r_m1_rdata <= (!r_we && !r_err) ? w_rd_word : 32'd0;
               end
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m0_ack        = r_m0_ack;
   assign m0_err        = r_m0_err;
   assign m0_rdata      = r_m0_rdata;
   assign m1_ack        = r_m1_ack;
   assign m1_err        = r_m1_err;
   assign m1_rdata      = r_m1_rdata;
   assign core_data_in  = r_data_in;
   assign core_write_en = r_write_en;
   assign core_read_en  = r_read_en;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter (REGS=3, ADDR_W=2).
module tb_core_bus_arbiter;

   logic          clk;
   logic          reset;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [1:0]    m0_addr, m1_addr;
   logic [31:0]   m0_wdata, m1_wdata;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0]   m0_rdata, m1_rdata;
   logic [31:0]   core_data_in;
   logic [95:0]   core_data_out;
   logic [2:0]    core_write_en, core_read_en;

   int n_cmp;
   int n_mis;

   core_bus_arbiter #(.REGS(3), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .core_data_in(core_data_in), .core_data_out(core_data_out),
      .core_write_en(core_write_en), .core_read_en(core_read_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_grant;   // 0 = m0, 1 = m1, per transaction

   initial begin
      n_cmp = 0;
      n_mis = 0;
      reset = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 2'd0; m0_wdata = 32'd0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 2'd0; m1_wdata = 32'd0;
      core_data_out = {32'h0000_CAFE, 32'h0000_BEEF, 32'h0000_1234};
`ifdef ARB_FIXED_PRIO_EN
      exp_grant = 4'b0000;
`else
      exp_grant = 4'b1010;
`endif

      cyc(); cyc();
      chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
      chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
      chk("rst_wen", {29'd0, core_write_en}, 32'd0);
      chk("rst_ren", {29'd0, core_read_en}, 32'd0);
      chk("rst_din", core_data_in, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      reset = 1'b0;

      // m0 write addr1 = 5
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 32'h0000_0005;
      cyc();
      chk("wr_wen", {29'd0, core_write_en}, 32'h2);
      chk("wr_ren", {29'd0, core_read_en}, 32'h0);
      chk("wr_din", core_data_in, 32'h5);
      chk("wr_early_ack", {31'd0, m0_ack}, 32'd0);
      cyc();
      chk("wr_wen_off", {29'd0, core_write_en}, 32'h0);
      chk("wr_din_off", core_data_in, 32'h0);
      chk("wr_ack", {31'd0, m0_ack}, 32'd1);
      chk("wr_err", {31'd0, m0_err}, 32'd0);
      chk("wr_rdata", m0_rdata, 32'd0);
      chk("wr_m1_ack", {31'd0, m1_ack}, 32'd0);
      m0_req = 1'b0;
      cyc();
      chk("wr_ack_pulse", {31'd0, m0_ack}, 32'd0);

      // m1 read addr0
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd0;
      cyc();
      chk("rd0_ren", {29'd0, core_read_en}, 32'h1);
      chk("rd0_wen", {29'd0, core_write_en}, 32'h0);
      chk("rd0_din", core_data_in, 32'h0);
      cyc();
      chk("rd0_ack", {31'd0, m1_ack}, 32'd1);
      chk("rd0_rdata", m1_rdata, 32'h0000_1234);
      chk("rd0_err", {31'd0, m1_err}, 32'd0);
      chk("rd0_m0_ack", {31'd0, m0_ack}, 32'd0);
      m1_req = 1'b0;
      cyc();

      // m1 read top valid address
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd2;
      cyc();
      chk("rd2_ren", {29'd0, core_read_en}, 32'h4);
      cyc();
      chk("rd2_ack", {31'd0, m1_ack}, 32'd1);
      chk("rd2_rdata", m1_rdata, 32'h0000_CAFE);
      m1_req = 1'b0;
      cyc();

      // m0 read out-of-range addr3
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2'd3;
      cyc();
      chk("oor_ren", {29'd0, core_read_en}, 32'h0);
      chk("oor_wen", {29'd0, core_write_en}, 32'h0);
      cyc();
      chk("oor_ack", {31'd0, m0_ack}, 32'd1);
      chk("oor_err", {31'd0, m0_err}, 32'd1);
      chk("oor_rdata", m0_rdata, 32'd0);
      m0_req = 1'b0;
      cyc();

      // Arbitration after a fresh reset, both held for 4 transactions
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd0; m0_wdata = 32'h0000_00AA;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 2'd2; m1_wdata = 32'h0000_00BB;
      for (int t = 0; t < 4; t++) begin
         cyc();
         chk($sformatf("arb%0d_wen", t), {29'd0, core_write_en}, exp_grant[t] ? 32'h4 : 32'h1);
         chk($sformatf("arb%0d_din", t), core_data_in, exp_grant[t] ? 32'hBB : 32'hAA);
         cyc();
         chk($sformatf("arb%0d_m0_ack", t), {31'd0, m0_ack}, exp_grant[t] ? 32'd0 : 32'd1);
         chk($sformatf("arb%0d_m1_ack", t), {31'd0, m1_ack}, exp_grant[t] ? 32'd1 : 32'd0);
         cyc();
      end
      m0_req = 1'b0; m1_req = 1'b0;
      cyc(); cyc(); cyc();

      // Reset in the ACCESS cycle of an m1 write
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 2'd1; m1_wdata = 32'h0000_0077;
      cyc();
      chk("rstacc_wen", {29'd0, core_write_en}, 32'h2);
      #2;
      reset = 1'b1;
      m1_req = 1'b0;
      #1;
      chk("rstacc_wen_drop", {29'd0, core_write_en}, 32'h0);
      chk("rstacc_din_drop", core_data_in, 32'h0);
      cyc();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("rstacc_noack%0d", k), {31'd0, m1_ack}, 32'd0);
      end
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2'd0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd1;
      cyc();
      chk("rstacc_next_ren", {29'd0, core_read_en}, 32'h1);
      cyc();
      chk("rstacc_next_m0_ack", {31'd0, m0_ack}, 32'd1);
      chk("rstacc_next_m0_rdata", m0_rdata, 32'h0000_1234);
      chk("rstacc_next_m1_ack", {31'd0, m1_ack}, 32'd0);
      m0_req = 1'b0; m1_req = 1'b0;
      cyc(); cyc(); cyc();
      // m1 was left pending, it must not have been started
      chk("rstacc_idle_wen", {29'd0, core_write_en | core_read_en}, 32'h0);

      // Back-to-back m0 writes with req held
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 32'h0000_0011;
      cyc();
      chk("b2b_wen1", {29'd0, core_write_en}, 32'h2);
      cyc();
      chk("b2b_ack1", {31'd0, m0_ack}, 32'd1);
      chk("b2b_wen1_off", {29'd0, core_write_en}, 32'h0);
      m0_addr = 2'd2; m0_wdata = 32'h0000_0022;
      cyc();
      chk("b2b_gap_wen", {29'd0, core_write_en}, 32'h0);
      chk("b2b_gap_ack", {31'd0, m0_ack}, 32'd0);
      cyc();
      chk("b2b_wen2", {29'd0, core_write_en}, 32'h4);
      chk("b2b_din2", core_data_in, 32'h22);
      chk("b2b_no_ack", {31'd0, m0_ack}, 32'd0);
      cyc();
      chk("b2b_ack2", {31'd0, m0_ack}, 32'd1);
      m0_req = 1'b0;
      cyc();
      chk("b2b_ack2_pulse", {31'd0, m0_ack}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
